// File: rtl/rand_pkg.sv
// Shared types and helpers for the random-number arbiter and its picker.
package rand_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STEP  = 2'd1,
      GRANT = 2'd2,
      ACK   = 2'd3
   } rand_state_t;

   localparam int unsigned RAND_W_DEF = 8;
   localparam int unsigned STEPS_MAX  = 15;
   localparam int unsigned REQ_MAX    = 8;

   // One-hot vector with bit idx set; callers cast down to their requester count.
   function automatic logic [REQ_MAX-1:0] onehot(input int unsigned idx);
      return {{(REQ_MAX-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/rand_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping at NUM_REQ.
module rr_pick #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [IW-1:0]      winner,
   output logic               valid
);

   // Search ptr+1, ptr+2, ... and keep the first hit.
   always_comb begin
      int unsigned idx;
      idx    = '0;
      winner = '0;
      valid  = 1'b0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         idx = (32'(ptr) + i) % NUM_REQ;
         if (!valid && req[IW'(idx)]) begin
            valid  = 1'b1;
            winner = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter sharing one LFSR among NUM_REQ requesters. Each grant
// advances the LFSR STEPS times, then returns its value with a one-cycle ack.
// Optional macro RAND_ARBITER_FREE_RUN_EN: LFSR also advances every IDLE cycle.
module rand_arbiter
   import rand_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 4,
   parameter  int unsigned RAND_W  = RAND_W_DEF,
   parameter  int unsigned STEPS   = 2,
   localparam int unsigned IW      = $clog2(NUM_REQ)
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic [RAND_W-1:0]  lfsr_random,
   output logic               lfsr_en,
   output logic [NUM_REQ-1:0] ack,
   output logic [IW-1:0]      grant_id,
   output logic [RAND_W-1:0]  rand_out,
   output logic               busy
);

   localparam int unsigned CW = $clog2(STEPS_MAX + 1);

   rand_state_t        state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [IW-1:0]      grant_id_q, grant_id_d;
   logic [RAND_W-1:0]  rand_out_q, rand_out_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;

   logic [IW-1:0]      pick_idx;
   logic               pick_valid;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .winner (pick_idx),
      .valid  (pick_valid)
   );

   // State and datapath registers; reset leaves requester 0 with top priority.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ptr_q      <= IW'(NUM_REQ - 1);
         grant_id_q <= '0;
         rand_out_q <= '0;
         ack_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         grant_id_q <= grant_id_d;
         rand_out_q <= rand_out_d;
         ack_q      <= ack_d;
      end
   end

   // Next-state and datapath updates: latch winner, count steps, capture value.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      grant_id_d = grant_id_q;
      rand_out_d = rand_out_q;
      ack_d      = '0;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               grant_id_d = pick_idx;
               cnt_d      = CW'(STEPS - 1);
               state_d    = STEP;
            end
         end
         STEP: begin
            if (cnt_q == '0) state_d = GRANT;
            else             cnt_d   = cnt_q - CW'(1);
         end
         GRANT: begin
            rand_out_d = lfsr_random;
            ack_d      = NUM_REQ'(onehot(32'(grant_id_q)));
            ptr_d      = grant_id_q;
            state_d    = ACK;
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      lfsr_en = 1'b0;
      busy    = 1'b1;
      unique case (state_q)
         IDLE: begin
            busy = 1'b0;
`ifdef RAND_ARBITER_FREE_RUN_EN
            lfsr_en = 1'b1;
`else
            lfsr_en = 1'b0;
`endif
         end
         STEP:    lfsr_en = 1'b1;
         default: lfsr_en = 1'b0;
      endcase
   end

   assign ack      = ack_q;
   assign grant_id = grant_id_q;
   assign rand_out = rand_out_q;

endmodule
